// File: rtl/activation_lookup_scheduler_if.sv
// Requester, ROM and response signals of the shared activation lookup engine.
interface activation_lookup_scheduler_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned INWIDTH   = 10
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATAWIDTH-1:0] sum_bus;
  logic [NUM_REQ-1:0]           func_bus;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic [INWIDTH-1:0]           tag_addr;
  logic [DATAWIDTH-1:0]         tag_data;
  logic [INWIDTH-1:0]           act_addr;
  logic [2*DATAWIDTH-1:0]       act_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [DATAWIDTH-1:0]         rsp_value;
  logic [DATAWIDTH-1:0]         rsp_tag;
  logic                         rsp_match;

  // Environment side: requesters, ROMs and response consumer
  modport master (
    output req, sum_bus, func_bus, tag_data, act_data, rsp_ready,
    input  grant, busy, tag_addr, act_addr, rsp_valid, rsp_id, rsp_value, rsp_tag, rsp_match
  );

  // Scheduler side
  modport slave (
    input  req, sum_bus, func_bus, tag_data, act_data, rsp_ready,
    output grant, busy, tag_addr, act_addr, rsp_valid, rsp_id, rsp_value, rsp_tag, rsp_match
  );
endinterface

// File: rtl/activation_lookup_scheduler.sv
// Round-robin shared tag-ROM binary search and activation-ROM lookup.
// Optional ACT_LOOKUP_STATS_EN adds saturating lookup / no-match counters.
// ROM addresses are loaded when entering ADDR/ACT so a synchronous ROM
// returns data in the following CMP/ACT_WAIT cycle.
module activation_lookup_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned INWIDTH    = 10,
  parameter int unsigned DIFF_CHECK = 32
) (
  input logic clock,
  input logic reset,
  activation_lookup_scheduler_if.slave bus
`ifdef ACT_LOOKUP_STATS_EN
  ,
  output logic [15:0] stat_lookups,
  output logic [15:0] stat_nomatch
`endif
);
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W  = INWIDTH + 1;
  localparam int unsigned DIFF_W = DATAWIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << INWIDTH) - 1);

  typedef enum logic [2:0] {IDLE, ADDR, CMP, ACT, ACT_WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic                 func_q, func_d;
  logic [IDX_W-1:0]     start_q, start_d, end_q, end_d;
  logic [INWIDTH-1:0]   best_idx_q, best_idx_d;
  logic [DIFF_W-1:0]    best_diff_q, best_diff_d;
  logic [DATAWIDTH-1:0] best_tag_q, best_tag_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [INWIDTH-1:0]   tag_addr_q, tag_addr_d, act_addr_q, act_addr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [DATAWIDTH-1:0] rsp_value_q, rsp_value_d, rsp_tag_q, rsp_tag_d;
  logic                 rsp_match_q, rsp_match_d;

  logic               found;
  logic [ID_W-1:0]    win;
  int unsigned        cand;
  logic [DIFF_W-1:0]  diff, abs_diff;
  logic               better, hit, tag_lt, done, handshake;
  logic [IDX_W-1:0]   mid_ext, next_start, next_end;
  logic [INWIDTH-1:0] new_best_idx;

  assign handshake = (state_q == RESP) && rsp_valid_q && bus.rsp_ready;

  // Round-robin pick: first requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = ID_W'(cand);
      end
    end
  end

  // Search step: distance to the probed tag and the next interval
  always_comb begin
    mid_ext      = {1'b0, tag_addr_q};
    diff         = {sum_q[DATAWIDTH-1], sum_q} - {bus.tag_data[DATAWIDTH-1], bus.tag_data};
    abs_diff     = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
    better       = (abs_diff < best_diff_q) ||
                   ((abs_diff == best_diff_q) && (tag_addr_q < best_idx_q));
    hit          = (abs_diff <= DIFF_W'(DIFF_CHECK));
    tag_lt       = $signed(bus.tag_data) < $signed(sum_q);
    next_start   = tag_lt ? (mid_ext + IDX_W'(1)) : start_q;
    next_end     = tag_lt ? end_q : (mid_ext - IDX_W'(1));
    done         = hit || (!tag_lt && (tag_addr_q == '0)) || (next_start > next_end);
    new_best_idx = better ? tag_addr_q : best_idx_q;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (found) state_d = ADDR;
      ADDR:     state_d = CMP;
      CMP:      state_d = done ? ACT : ADDR;
      ACT:      state_d = ACT_WAIT;
      ACT_WAIT: state_d = RESP;
      RESP:     if (handshake) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of datapath and registered outputs
  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    sum_d       = sum_q;
    func_d      = func_q;
    start_d     = start_q;
    end_d       = end_q;
    best_idx_d  = best_idx_q;
    best_diff_d = best_diff_q;
    best_tag_d  = best_tag_q;
    grant_d     = '0;
    busy_d      = busy_q;
    tag_addr_d  = tag_addr_q;
    act_addr_d  = act_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_value_d = rsp_value_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_match_d = rsp_match_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d     = NUM_REQ'(1) << win;
        ptr_d       = (32'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
        id_d        = win;
        sum_d       = bus.sum_bus[win*DATAWIDTH +: DATAWIDTH];
        func_d      = bus.func_bus[win];
        start_d     = '0;
        end_d       = LAST_IDX;
        best_diff_d = '1;
        busy_d      = 1'b1;
        tag_addr_d  = INWIDTH'(LAST_IDX >> 1);
      end
      CMP: begin
        if (better) begin
          best_idx_d  = tag_addr_q;
          best_diff_d = abs_diff;
          best_tag_d  = bus.tag_data;
        end
        start_d = next_start;
        end_d   = next_end;
        if (done) act_addr_d = new_best_idx;
        else      tag_addr_d = INWIDTH'((next_start + next_end) >> 1);
      end
      ACT_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_value_d = func_q ? bus.act_data[DATAWIDTH-1:0]
                             : bus.act_data[2*DATAWIDTH-1:DATAWIDTH];
        rsp_tag_d   = best_tag_q;
        rsp_match_d = (best_diff_q <= DIFF_W'(DIFF_CHECK));
      end
      RESP: if (handshake) begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      func_q      <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      best_idx_q  <= '0;
      best_diff_q <= '1;
      best_tag_q  <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      tag_addr_q  <= '0;
      act_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_value_q <= '0;
      rsp_tag_q   <= '0;
      rsp_match_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      func_q      <= func_d;
      start_q     <= start_d;
      end_q       <= end_d;
      best_idx_q  <= best_idx_d;
      best_diff_q <= best_diff_d;
      best_tag_q  <= best_tag_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      tag_addr_q  <= tag_addr_d;
      act_addr_q  <= act_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_value_q <= rsp_value_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_match_q <= rsp_match_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.tag_addr  = tag_addr_q;
  assign bus.act_addr  = act_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_match = rsp_match_q;

`ifdef ACT_LOOKUP_STATS_EN
  // Saturating counters of completed lookups and of lookups without a match
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_nomatch <= '0;
    end else if (handshake) begin
      if (stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
      if (!rsp_match_q && (stat_nomatch != 16'hFFFF)) stat_nomatch <= stat_nomatch + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_activation_lookup_scheduler.sv
// Directed bench: one scheduler with DIFF_CHECK=32 and one with DIFF_CHECK=8
// share the same stimulus; each has its own synchronous tag/activation ROMs.
module tb_activation_lookup_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] sum_bus = '0;
  logic [3:0]  func_bus = '0;
  logic        rsp_ready = 1'b1;
  logic        sel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  activation_lookup_scheduler_if #(.NUM_REQ(4), .DATAWIDTH(16), .INWIDTH(10)) ifa ();
  activation_lookup_scheduler_if #(.NUM_REQ(4), .DATAWIDTH(16), .INWIDTH(10)) ifb ();

`ifdef ACT_LOOKUP_STATS_EN
  logic [15:0] stat_lookups_a, stat_nomatch_a, stat_lookups_b, stat_nomatch_b;
`endif

  activation_lookup_scheduler #(.NUM_REQ(4), .DATAWIDTH(16), .INWIDTH(10), .DIFF_CHECK(32)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.slave)
`ifdef ACT_LOOKUP_STATS_EN
    , .stat_lookups(stat_lookups_a), .stat_nomatch(stat_nomatch_a)
`endif
  );

  activation_lookup_scheduler #(.NUM_REQ(4), .DATAWIDTH(16), .INWIDTH(10), .DIFF_CHECK(8)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave)
`ifdef ACT_LOOKUP_STATS_EN
    , .stat_lookups(stat_lookups_b), .stat_nomatch(stat_nomatch_b)
`endif
  );

  assign ifa.req = req;       assign ifb.req = req;
  assign ifa.sum_bus = sum_bus;   assign ifb.sum_bus = sum_bus;
  assign ifa.func_bus = func_bus; assign ifb.func_bus = func_bus;
  assign ifa.rsp_ready = rsp_ready; assign ifb.rsp_ready = rsp_ready;

  function automatic logic [15:0] tag_rom(input logic [9:0] i);
    int v;
    v = (int'(i) - 512) * 64;
    return 16'(v);
  endfunction

  function automatic logic [31:0] act_rom(input logic [9:0] i);
    return {6'b0, i, 6'b0, ~i};
  endfunction

  // Synchronous ROM models
  always @(posedge clock) begin
    ifa.tag_data <= tag_rom(ifa.tag_addr);
    ifa.act_data <= act_rom(ifa.act_addr);
    ifb.tag_data <= tag_rom(ifb.tag_addr);
    ifb.act_data <= act_rom(ifb.act_addr);
  end

  logic [3:0]  obs_grant;
  logic        obs_busy, obs_valid, obs_match;
  logic [1:0]  obs_id;
  logic [15:0] obs_value, obs_tag;
  logic [9:0]  obs_tag_addr, obs_act_addr;

  // Observe the instance under test
  always_comb begin
    obs_grant    = sel ? ifb.grant     : ifa.grant;
    obs_busy     = sel ? ifb.busy      : ifa.busy;
    obs_valid    = sel ? ifb.rsp_valid : ifa.rsp_valid;
    obs_match    = sel ? ifb.rsp_match : ifa.rsp_match;
    obs_id       = sel ? ifb.rsp_id    : ifa.rsp_id;
    obs_value    = sel ? ifb.rsp_value : ifa.rsp_value;
    obs_tag      = sel ? ifb.rsp_tag   : ifa.rsp_tag;
    obs_tag_addr = sel ? ifb.tag_addr  : ifa.tag_addr;
    obs_act_addr = sel ? ifb.act_addr  : ifa.act_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (obs_grant != 0) begin
        g = obs_grant;
        break;
      end
    end
    if (g == 0) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      lat++;
      if (obs_valid) break;
    end
    if (!obs_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_grant"}, 32'(obs_grant), 0);
    check({tag, "_busy"}, 32'(obs_busy), 0);
    check({tag, "_valid"}, 32'(obs_valid), 0);
    check({tag, "_id"}, 32'(obs_id), 0);
    check({tag, "_value"}, 32'(obs_value), 0);
    check({tag, "_tag"}, 32'(obs_tag), 0);
    check({tag, "_match"}, 32'(obs_match), 0);
    check({tag, "_tag_addr"}, 32'(obs_tag_addr), 0);
    check({tag, "_act_addr"}, 32'(obs_act_addr), 0);
  endtask

  // Single lookup on lane-replicated inputs, response consumed immediately
  task automatic lookup(input string tag, input logic [3:0] r, input logic [15:0] s, input logic f,
                        input logic [3:0] exp_g, input logic [1:0] exp_id, input logic [15:0] exp_tag,
                        input logic [15:0] exp_val, input logic exp_match);
    logic [3:0] g;
    int lat;
    req = r; sum_bus = {4{s}}; func_bus = {4{f}};
    wait_grant(g);
    req = '0;
    check({tag, "_grant"}, 32'(g), 32'(exp_g));
    wait_rsp(lat);
    check({tag, "_latency_ok"}, 32'(lat <= 24), 1);
    check({tag, "_id"}, 32'(obs_id), 32'(exp_id));
    check({tag, "_tag"}, 32'(obs_tag), 32'(exp_tag));
    check({tag, "_value"}, 32'(obs_value), 32'(exp_val));
    check({tag, "_match"}, 32'(obs_match), 32'(exp_match));
    step();
    check({tag, "_done_valid"}, 32'(obs_valid), 0);
    check({tag, "_done_busy"}, 32'(obs_busy), 0);
  endtask

  initial begin
    logic [3:0] g;
    int lat;
    logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    do_reset();
    check_reset_state("rst");

    lookup("zero",  4'b0001, 16'h0000, 1'b0, 4'b0001, 2'd0, 16'h0000, 16'd512, 1'b1);
    do_reset();
    lookup("near",  4'b0010, 16'd33,   1'b1, 4'b0010, 2'd1, 16'd64,   16'd510, 1'b1);
    do_reset();
    lookup("min",   4'b0001, 16'h8000, 1'b0, 4'b0001, 2'd0, 16'h8000, 16'd0,   1'b1);
    check("min_act_addr", 32'(obs_act_addr), 0);
    do_reset();
    lookup("max",   4'b0001, 16'h7FFF, 1'b0, 4'b0001, 2'd0, 16'h7FC0, 16'd1023, 1'b0);
    check("max_act_addr", 32'(obs_act_addr), 1023);

    // Tie between 512 and 513 on the DIFF_CHECK=8 instance
    do_reset();
    sel = 1'b1;
    lookup("tie",   4'b0001, 16'd32,   1'b0, 4'b0001, 2'd0, 16'h0000, 16'd512, 1'b0);
    sel = 1'b0;

    // Round-robin order with all requesters held
    do_reset();
    req = 4'b1111; sum_bus = '0; func_bus = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check($sformatf("rr%0d_grant", k), 32'(g), 32'(rr_grant[k]));
      wait_rsp(lat);
      check($sformatf("rr%0d_id", k), 32'(obs_id), 32'(rr_id[k]));
    end
    req = '0;
    step();
    step();

    // Back-pressure: response held, no new grant while stalled
    do_reset();
    rsp_ready = 1'b0;
    req = 4'b0010; sum_bus = {4{16'd33}}; func_bus = 4'b1111;
    wait_grant(g);
    check("stall_grant", 32'(g), 32'b0010);
    req = 4'b1111;
    wait_rsp(lat);
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_valid", 32'(obs_valid), 1);
      check("stall_grant_idle", 32'(obs_grant), 0);
      check("stall_value", 32'(obs_value), 510);
      check("stall_tag", 32'(obs_tag), 64);
      check("stall_id", 32'(obs_id), 1);
    end
    req = '0;
    rsp_ready = 1'b1;
    step();
    check("stall_release_valid", 32'(obs_valid), 0);
    check("stall_release_busy", 32'(obs_busy), 0);

    // Reset in the middle of a long search
    do_reset();
    req = 4'b0001; sum_bus = {4{16'h7FFF}}; func_bus = '0;
    wait_grant(g);
    req = '0;
    repeat (5) step();
    check("mid_busy", 32'(obs_busy), 1);
    reset = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0;
    repeat (4) step();
    check("midrst_no_regrant", 32'(obs_busy), 0);
    check("midrst_no_grant", 32'(obs_grant), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
